// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin grant among NPORT inputs, held until
// the winner's tail flit crosses, with every transfer gated by downstream credits.
module output_port_arbiter #(
  parameter int NPORT    = 5,
  parameter int CREDITS  = 4,
  parameter int CREDIT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    flit_tail,
  input  logic                credit_in,
  output logic [NPORT-1:0]    grant,
  output logic [NPORT-1:0]    pop,
  output logic                fire,
  output logic [CREDIT_W-1:0] credit_cnt,
  output logic                busy
);

  localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [NPORT-1:0]      grant_q, grant_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [NPORT-1:0]      win_oh;
  logic [PTR_W-1:0]      g_idx, g_next;
  logic                  req_g, tail_g;

  // First requester at or after p, wrapping modulo NPORT.
  function automatic logic [NPORT-1:0] rr_pick(input logic [NPORT-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [NPORT-1:0] oh;
    logic             hit;
    int               idx;
    oh  = '0;
    hit = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      idx = int'(p) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!hit && r[idx]) begin
        oh[idx] = 1'b1;
        hit     = 1'b1;
      end
    end
    return oh;
  endfunction

  always_comb begin
    win_oh = rr_pick(req, ptr_q);
    g_idx  = '0;
    for (int i = 0; i < NPORT; i++)
      if (grant_q[i]) g_idx = PTR_W'(i);
    g_next = (g_idx == PTR_W'(NPORT-1)) ? '0 : g_idx + 1'b1;
    req_g  = |(req & grant_q);
    tail_g = |(flit_tail & grant_q);
  end

  // Registered count only: a credit arriving at zero enables fire next cycle.
  assign fire       = (state_q == LOCKED) && req_g && (credit_q != '0);
  assign pop        = fire ? grant_q : '0;
  assign grant      = grant_q;
  assign credit_cnt = credit_q;
  assign busy       = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (|req) begin
        grant_d = win_oh;
        state_d = LOCKED;
      end
      LOCKED: if (fire && tail_g) begin
        grant_d = '0;
        ptr_d   = g_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (fire && !credit_in)                          credit_d = credit_q - 1'b1;
    else if (!fire && credit_in && credit_q != CRED_MAX) credit_d = credit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      credit_q <= CRED_MAX;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  always_ff @(posedge clk)
    if (rst) assert ($onehot0(grant_q));

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port wormhole arbiter for the 5-port router: one instance per output port, sitting in front of the one-hot crossbar select for that port.
- Shares the output port among the five input ports (local, N, E, S, W) with round-robin fairness.
- Locks the port to the winner until that winner's tail flit has been transferred.
- Gates every flit transfer on downstream buffer credits.

Parameters:
- NPORT, 5, number of input ports competing for this output; bit i corresponds to input port i.
- CREDITS, 4, downstream input-buffer depth in flits; the credit counter's reset value.
- CREDIT_W, 3, credit counter width; must satisfy 2^CREDIT_W > CREDITS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- req  in  NPORT  input i holds a valid flit routed to this output port.
- flit_tail  in  NPORT  flit currently presented by input i is a tail; a single-flit packet has its head and tail in the same flit.
- credit_in  in  1  downstream freed one buffer slot this cycle (1-cycle pulse).
- grant  out  NPORT  registered one-hot (or zero) crossbar select for this output.
- pop  out  NPORT  one-hot read enable to the winning input buffer; equals grant when fire=1, else 0; combinational.
- fire  out  1  a flit crosses the crossbar this cycle; combinational.
- credit_cnt  out  CREDIT_W  current downstream credits.
- busy  out  1  1 while in LOCKED.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grant=0, ptr=0, credit_cnt=CREDITS, busy=0.
  - fire=0 and pop=0 follow directly from these values.
- Round-robin pointer ptr, range 0..NPORT-1: the highest-priority index for the next arbitration.
- IDLE:
  - grant=0, fire=0.
  - If req != 0: winner = the first i with req[i]=1, searching ptr, ptr+1, ... with modulo-NPORT wrap.
  - On the next edge: grant <= onehot(winner), state <= LOCKED.
  - Latency: req asserted in cycle N gives grant visible in cycle N+1; the first flit can fire in cycle N+1.
  - If req=0: remain in IDLE.
- LOCKED, with g the index of the grant bit:
  - fire = req[g] & (credit_cnt != 0).
  - No new arbitration occurs; requests from other inputs are ignored.
  - fire=1 with flit_tail[g]=1: on the edge, grant <= 0, ptr <= (g+1) mod NPORT, state <= IDLE.
  - At least one idle cycle separates consecutive packets on this port: no same-cycle re-grant.
  - fire=1 with flit_tail[g]=0: stay LOCKED.
  - req[g]=0 mid-packet (upstream bubble): hold the lock; fire=0; credits unchanged.
  - credit_cnt=0: fire=0; stay LOCKED until a credit returns.
- Credit counter, updated on each edge:
  - fire only: credit_cnt-1.
  - credit_in only: credit_cnt+1.
  - fire and credit_in together: unchanged.
  - credit_in while credit_cnt=CREDITS (protocol error): saturate at CREDITS; no wrap.
  - fire cannot occur at credit_cnt=0 by construction, so the counter never underflows.
- A credit returned in the same cycle that credit_cnt=0 does not enable fire in that cycle. fire uses the registered count, so it is enabled the next cycle.
- grant is always one-hot or zero; two or more bits set is illegal and is an assertion target.
- flit_tail[i] is sampled only when i=g and fire=1; it is don't-care otherwise.
- Reset asserted mid-packet: the lock and pointer are cleared at once; the partial packet is the upstream/downstream reset's concern.

Test Plan:
- Reset, then req=5'b00100 with a 3-flit packet (tail on the 3rd flit), CREDITS=4 → grant=5'b00100 in the cycle after req; fire on 3 consecutive cycles; credit_cnt 4→1; then grant=0 and ptr=3.
- req=5'b11111 held, single-flit packets (tail=1 on every flit), credit_in returned each fire, ptr=0 → grants in order 00001, 00010, 00100, 01000, 10000, 00001, each separated by one IDLE cycle.
- Locked on input 1 with credit_cnt=0 and req=5'b11111 → fire=0, grant stays 00010. Pulse credit_in → fire=1 on the following cycle; no other input is granted.
- Locked on input 3 mid-packet, req[3] dropped for 2 cycles → grant holds 01000, fire=0, credit_cnt unchanged. When req[3] returns, the remaining flits fire.
- fire and credit_in in the same cycle at credit_cnt=2 → stays 2. credit_in at credit_cnt=4 → stays 4.
- rst=0 pulsed while LOCKED on input 4 with credit_cnt=1 → grant=0, busy=0 and credit_cnt=4 immediately, without waiting for a clock edge. Next arbitration with req=5'b10001 grants input 0 (ptr=0).
